// File: rtl/multiply_acc_ctrl.sv
// rtl/multiply_acc_ctrl.sv - job sequencer for one multiply_acc lane
// Optional MULTIPLY_ACC_CTRL_RELU_EN clamps negative captured sums to zero.
module multiply_acc_ctrl #(
  parameter int IMG_WIDTH   = 16,
  parameter int KER_WIDTH   = 16,
  parameter int LEN_WIDTH   = 12,
  parameter int MAC_LATENCY = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LEN_WIDTH-1:0]           cfg_len,
  input  logic                           cfg_start,
  output logic                           cfg_busy,
  input  logic [IMG_WIDTH-1:0]           in_img,
  input  logic [KER_WIDTH-1:0]           in_ker,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           mac_rst,
  output logic [IMG_WIDTH-1:0]           mac_img,
  output logic [KER_WIDTH-1:0]           mac_ker,
  output logic                           mac_val,
  input  logic [IMG_WIDTH+KER_WIDTH:0]   mac_result,
  output logic [IMG_WIDTH+KER_WIDTH:0]   res_data,
  output logic                           res_valid,
  input  logic                           res_ready
);

  localparam int RES_W  = IMG_WIDTH + KER_WIDTH + 1;
  localparam int DCNT_W = $clog2(MAC_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] len_r;
  logic [LEN_WIDTH-1:0] acc_cnt;
  logic [DCNT_W-1:0]    drain_cnt;
  logic [RES_W-1:0]     capture_val;
  logic                 accept;
  logic                 last_pair;
  logic                 drain_done;

  assign mac_img  = in_img;
  assign mac_ker  = in_ker;
  assign in_ready = (state == RUN);
  assign mac_val  = in_valid & in_ready;
  assign mac_rst  = rst | (state == CLEAR);
  assign cfg_busy = (state != IDLE);

  assign accept     = mac_val;
  // RUN is only entered with len_r != 0, so len_r - 1 never underflows here
  assign last_pair  = accept && (acc_cnt == len_r - LEN_WIDTH'(1));
  assign drain_done = (drain_cnt == DCNT_W'(MAC_LATENCY - 1));

`ifdef MULTIPLY_ACC_CTRL_RELU_EN
  assign capture_val = mac_result[RES_W-1] ? '0 : mac_result;
`else
  assign capture_val = mac_result;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = CLEAR;
      CLEAR:   state_nxt = (len_r != '0) ? RUN : DRAIN;
      RUN:     if (last_pair) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = OUT;
      OUT:     if (res_valid && res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_r     <= '0;
      acc_cnt   <= '0;
      drain_cnt <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cfg_start) len_r <= cfg_len;
          acc_cnt   <= '0;
          drain_cnt <= '0;
        end
        CLEAR: begin
          acc_cnt   <= '0;
          drain_cnt <= '0;
        end
        RUN: begin
          if (accept) acc_cnt <= acc_cnt + LEN_WIDTH'(1);
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DCNT_W'(1);
          if (drain_done) begin
            res_data  <= capture_val;
            res_valid <= 1'b1;
          end
        end
        OUT: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multiply_acc_ctrl.md
Name: multiply_acc_ctrl

Overview:
- Sequencer for one `multiply_acc` lane.
- For each job it clears the MAC, streams `cfg_len` image/kernel element pairs into it, and waits out the MAC pipeline.
- It then captures the accumulated dot product and presents it on a valid/ready result port.
- Sits between the window/kernel fetch logic and the layer output writer.

Parameters:
- IMG_WIDTH, 16, image element width (signed)
- KER_WIDTH, 16, kernel element width (signed)
- LEN_WIDTH, 12, width of the job length field
- MAC_LATENCY, 5, cycles from the MAC accepting an element to that element appearing in `mac_result`

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_len  in  LEN_WIDTH  number of element pairs in the job (unsigned)
- cfg_start  in  1  start pulse; sampled only in IDLE
- cfg_busy  out  1  high in any state except IDLE
- in_img  in  IMG_WIDTH  image element
- in_ker  in  KER_WIDTH  kernel element
- in_valid  in  1  element pair valid
- in_ready  out  1  controller accepts the pair this cycle
- mac_rst  out  1  drives the MAC `rst`
- mac_img  out  IMG_WIDTH  drives the MAC `img`
- mac_ker  out  KER_WIDTH  drives the MAC `ker`
- mac_val  out  1  drives the MAC `val`
- mac_result  in  IMG_WIDTH+KER_WIDTH+1  MAC `result`
- res_data  out  IMG_WIDTH+KER_WIDTH+1  captured signed sum
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready

Behaviour:
- Reset (synchronous, active-high; clock `clk`, reset `rst`):
  - state = IDLE, counters = 0.
  - cfg_busy = 0, in_ready = 0, res_valid = 0, res_data = 0, mac_val = 0.
  - mac_rst = 1 while `rst` is high, so the MAC clears with the controller.
- Combinational outputs:
  - mac_img = in_img; mac_ker = in_ker.
  - in_ready = (state == RUN).
  - mac_val = in_valid & in_ready.
  - mac_rst = rst | (state == CLEAR).
- IDLE:
  - On cfg_start, latch cfg_len into len_r and go to CLEAR.
- CLEAR (exactly 1 cycle):
  - mac_rst = 1, mac_val = 0.
  - Next state is RUN if len_r != 0, otherwise DRAIN.
- RUN:
  - Each cycle with in_valid & in_ready is one accepted pair; acc_cnt increments.
  - Cycles with in_valid = 0 are bubbles: mac_val = 0, so the MAC adds 0.
  - When the accepted pair makes acc_cnt == len_r, go to DRAIN.
- DRAIN:
  - Counts exactly MAC_LATENCY cycles; in_ready = 0.
  - On the final DRAIN clock edge, res_data <= mac_result; res_valid <= 1; go to OUT.
- OUT:
  - Hold res_data and res_valid until res_valid & res_ready; then res_valid <= 0 and go to IDLE.
  - cfg_start is not accepted in the same cycle as the handshake.
- Latency:
  - Last pair accepted in cycle c gives res_valid = 1 in cycle c + MAC_LATENCY + 1 (c+6 with defaults).
  - cfg_start in cycle s with len = N and no bubbles gives the first in_ready in cycle s+2 and res_valid in cycle s+N+7.
- Arithmetic:
  - res_data is the full-width signed two's-complement sum.
  - No saturation; overflow wraps within IMG_WIDTH+KER_WIDTH+1 bits.
- Boundaries:
  - cfg_start while busy is ignored; cfg_len is not re-sampled.
  - len = 0 produces res_data = 0.
  - len = 2^LEN_WIDTH−1 must complete; acc_cnt must not wrap.
  - rst mid-job aborts to IDLE, drops any pending result and clears the MAC.

Optional Feature:
- Macro: MULTIPLY_ACC_CTRL_RELU_EN.
- Defined: at capture, a negative mac_result (MSB = 1) is stored as 0 in res_data; non-negative values are stored unchanged. Latency is unchanged.
- Undefined: res_data is the raw signed sum.

Test Plan:
- len=3, pairs (2,4),(3,5),(−1,6), no bubbles, res_ready=1 -> res_data=17; res_valid exactly 6 cycles after the last accept; single-cycle res_valid pulse.
- len=4, in_valid toggling 1,0,1,0,..., pairs (1,1),(2,2),(3,3),(4,4) -> res_data=30; bubbles do not count; mac_val never high while in_ready=0.
- len=1, pair (−4,5), res_ready held low 10 cycles -> res_data=−20 (0 with MULTIPLY_ACC_CTRL_RELU_EN) stable for all 10 cycles; cfg_start pulses during OUT ignored; IDLE the cycle after the handshake.
- Back-to-back jobs: len=2 (7,7),(1,1) then len=2 (1,1),(1,1) -> results 50 then 2; second result not polluted by first (CLEAR works).
- len=0 -> mac_rst high 1 cycle, no in_ready; res_data=0 after DRAIN.
- rst asserted mid-RUN after 2 of 5 pairs -> next cycle IDLE, res_valid=0, cfg_busy=0; new len=1 job (3,3) returns 9.
